bus_requester: RTL and testbench

Per-core initiator for the shared `systembus` arbiter. It accepts load/store commands from a core, raises `request`, holds address/data/write-enable stable until the arbiter returns `grant`, then completes the transfer. For reads it captures `memdata`. It returns the result to the core with a one-cycle `cpu_done` pulse. One instance sits between each core and its `requestN`/`grantN`/`adrN`/`writedataN`/`memwriteN` slice of the bus. It buffers one pending command behind the active one, so back-to-back accesses keep `request` high continuously.

---
 rtl/bus_requester.sv | 172 +++++++++++++++++
 tb/tb_bus_requester.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_requester.sv
// Per-core bus initiator: one active and one pending command; request held until grant.
// Optional grant-wait abort is enabled by defining BUS_REQUESTER_TIMEOUT_EN.
module bus_requester #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAXWAIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_ready,
  output logic             cpu_done,
  output logic             cpu_err,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             request,
  input  logic             grant,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  output logic             memwrite,
  input  logic [WIDTH-1:0] memdata
);

  typedef enum logic {IDLE, REQ} state_e;

  if (MAXWAIT < 1) begin : g_maxwait_check
    $error("bus_requester: MAXWAIT must be at least 1");
  end

  state_e             state_q, state_d;
  logic               a_we_q, a_we_d;
  logic [WIDTH-1:0]   a_adr_q, a_adr_d, a_wdata_q, a_wdata_d;
  logic               p_valid_q, p_valid_d, p_we_q, p_we_d;
  logic [WIDTH-1:0]   p_adr_q, p_adr_d, p_wdata_q, p_wdata_d;
  logic               ready_q, ready_d, done_q, done_d, err_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               request_q, request_d, memwrite_q, memwrite_d;
  logic [WIDTH-1:0]   adr_q, adr_d, writedata_q, writedata_d;
  logic               accept, timeout;

`ifdef BUS_REQUESTER_TIMEOUT_EN
  localparam int unsigned WAITW = $clog2(MAXWAIT + 1);
  logic [WAITW-1:0] wait_q, wait_d;
  logic             err_q;
  assign timeout = (state_q == REQ) && !grant && (wait_q == WAITW'(MAXWAIT - 1));
`else
  assign timeout = 1'b0;
`endif

  assign accept = cpu_req && ready_q;

  always_comb begin
    state_d   = state_q;
    a_we_d    = a_we_q;
    a_adr_d   = a_adr_q;
    a_wdata_d = a_wdata_q;
    p_valid_d = p_valid_q;
    p_we_d    = p_we_q;
    p_adr_d   = p_adr_q;
    p_wdata_d = p_wdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // A pending entry left behind by an abort is issued before new work.
        if (p_valid_q) begin
          {a_we_d, a_adr_d, a_wdata_d} = {p_we_q, p_adr_q, p_wdata_q};
          p_valid_d = 1'b0;
          state_d   = REQ;
        end else if (accept) begin
          {a_we_d, a_adr_d, a_wdata_d} = {cpu_we, cpu_adr, cpu_wdata};
          state_d = REQ;
        end
      end
      REQ: begin
        if (grant) begin
          done_d = 1'b1;
          if (!a_we_q) rdata_d = memdata;
          if (p_valid_q) begin
            {a_we_d, a_adr_d, a_wdata_d} = {p_we_q, p_adr_q, p_wdata_q};
            p_valid_d = 1'b0;
          end else if (accept) begin
            {a_we_d, a_adr_d, a_wdata_d} = {cpu_we, cpu_adr, cpu_wdata};
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (accept) begin
            {p_we_d, p_adr_d, p_wdata_d} = {cpu_we, cpu_adr, cpu_wdata};
            p_valid_d = 1'b1;
          end
          if (timeout) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from next-state values so they change on the same edge as the state.
    request_d   = (state_d == REQ);
    adr_d       = request_d ? a_adr_d : '0;
    writedata_d = request_d ? a_wdata_d : '0;
    memwrite_d  = request_d && a_we_d;
    ready_d     = !p_valid_d;
  end

`ifdef BUS_REQUESTER_TIMEOUT_EN
  assign wait_d = (state_q == REQ && state_d == REQ && !grant) ? wait_q + WAITW'(1) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
  assign cpu_err = err_q;
`else
  assign cpu_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_we_q      <= 1'b0;
      a_adr_q     <= '0;
      a_wdata_q   <= '0;
      p_valid_q   <= 1'b0;
      p_we_q      <= 1'b0;
      p_adr_q     <= '0;
      p_wdata_q   <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      request_q   <= 1'b0;
      adr_q       <= '0;
      writedata_q <= '0;
      memwrite_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_we_q      <= a_we_d;
      a_adr_q     <= a_adr_d;
      a_wdata_q   <= a_wdata_d;
      p_valid_q   <= p_valid_d;
      p_we_q      <= p_we_d;
      p_adr_q     <= p_adr_d;
      p_wdata_q   <= p_wdata_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      request_q   <= request_d;
      adr_q       <= adr_d;
      writedata_q <= writedata_d;
      memwrite_q  <= memwrite_d;
    end
  end

  assign cpu_ready = ready_q;
  assign cpu_done  = done_q;
  assign cpu_rdata = rdata_q;
  assign request   = request_q;
  assign adr       = adr_q;
  assign writedata = writedata_q;
  assign memwrite  = memwrite_q;

endmodule

// File: tb/tb_bus_requester.sv
// Bench for bus_requester: directed vector table, hand sequences, and a queue-based reference model.
module tb_bus_requester;
  localparam int W = 8;
`ifdef BUS_REQUESTER_TIMEOUT_EN
  localparam int unsigned MW = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int unsigned MW = 16;
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_we, grant;
  logic [W-1:0] cpu_adr, cpu_wdata, memdata;
  logic         cpu_ready, cpu_done, cpu_err, request, memwrite;
  logic [W-1:0] cpu_rdata, adr, writedata;

  always #5 clk = ~clk;

  bus_requester #(.WIDTH(W), .MAXWAIT(MW)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .request(request), .grant(grant), .adr(adr),
    .writedata(writedata), .memwrite(memwrite), .memdata(memdata)
  );

  int errors = 0;
  int checks = 0;
  bit use_model = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of outstanding commands; front is on the bus when busy.
  typedef struct packed { logic we; logic [W-1:0] adr; logic [W-1:0] wdata; } cmd_t;
  cmd_t         mq[$];
  bit           m_busy, m_ready, m_done, m_err;
  int           m_wait;
  logic [W-1:0] m_rdata;

  function automatic void model_reset();
    mq.delete();
    m_busy = 0; m_ready = 0; m_done = 0; m_err = 0; m_wait = 0; m_rdata = '0;
  endfunction

  function automatic void model_edge();
    bit   acc = cpu_req && m_ready;
    cmd_t c;
    c = '{we: cpu_we, adr: cpu_adr, wdata: cpu_wdata};
    m_done = 0; m_err = 0;
    if (m_busy && grant) begin
      if (!mq[0].we) m_rdata = memdata;
      void'(mq.pop_front());
      m_done = 1;
      if (acc) mq.push_back(c);
      m_busy = (mq.size() > 0);
      m_wait = 0;
    end else if (m_busy && TO_EN && m_wait == int'(MW) - 1) begin
      void'(mq.pop_front());
      m_done = 1; m_err = 1;
      if (acc) mq.push_back(c);
      m_busy = 0;
      m_wait = 0;
    end else if (m_busy) begin
      m_wait++;
      if (acc) mq.push_back(c);
    end else begin
      if (acc) mq.push_back(c);
      m_busy = (mq.size() > 0);
      m_wait = 0;
    end
    m_ready = ((mq.size() - int'(m_busy)) == 0);
  endfunction

  task automatic model_check();
    chk("m_request", request, m_busy);
    chk("m_adr", adr, m_busy ? mq[0].adr : '0);
    chk("m_writedata", writedata, m_busy ? mq[0].wdata : '0);
    chk("m_memwrite", memwrite, m_busy ? mq[0].we : 1'b0);
    chk("m_done", cpu_done, m_done);
    chk("m_err", cpu_err, m_err);
    chk("m_rdata", cpu_rdata, m_rdata);
    chk("m_ready", cpu_ready, m_ready);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (use_model) model_check();
  endtask

  task automatic drive(input logic rq, input logic we, input logic [W-1:0] a,
                       input logic [W-1:0] wd, input logic g, input logic [W-1:0] md);
    cpu_req = rq; cpu_we = we; cpu_adr = a; cpu_wdata = wd; grant = g; memdata = md;
  endtask

  typedef struct {
    logic rq, we; logic [W-1:0] a, wd; logic g; logic [W-1:0] md;
    logic e_req; logic [W-1:0] e_adr; logic e_mw; logic [W-1:0] e_wd;
    logic e_done; logic [W-1:0] e_rdata; logic e_ready;
  } vec_t;
  vec_t vt[20];

  logic [W-1:0] saved_rdata;

  initial begin
    // rq we adr wd g md | req adr mw wd done rdata ready
    vt[0]  = '{1,0,5,0,0,0,     1,5,0,0,0,0,1};
    vt[1]  = '{0,0,0,0,0,0,     1,5,0,0,0,0,1};
    vt[2]  = '{0,0,0,0,0,0,     1,5,0,0,0,0,1};
    vt[3]  = '{0,0,0,0,1,207,   0,0,0,0,1,207,1};
    vt[4]  = '{0,0,0,0,0,0,     0,0,0,0,0,207,1};
    vt[5]  = '{1,1,5,55,0,0,    1,5,1,55,0,207,1};
    vt[6]  = '{0,0,0,0,1,99,    0,0,0,0,1,207,1};
    vt[7]  = '{0,0,0,0,0,0,     0,0,0,0,0,207,1};
    vt[8]  = '{1,0,5,0,1,11,    1,5,0,0,0,207,1};
    vt[9]  = '{1,0,6,0,1,22,    1,6,0,0,1,22,1};
    vt[10] = '{0,0,0,0,1,33,    0,0,0,0,1,33,1};
    vt[11] = '{0,0,0,0,0,0,     0,0,0,0,0,33,1};
    vt[12] = '{1,0,1,0,0,0,     1,1,0,0,0,33,1};
    vt[13] = '{1,0,2,0,0,0,     1,1,0,0,0,33,0};
    vt[14] = '{1,0,3,0,0,0,     1,1,0,0,0,33,0};
    vt[15] = '{1,0,3,0,1,44,    1,2,0,0,1,44,1};
    vt[16] = '{1,0,3,0,0,0,     1,2,0,0,0,44,0};
    vt[17] = '{0,0,0,0,1,55,    1,3,0,0,1,55,1};
    vt[18] = '{0,0,0,0,1,66,    0,0,0,0,1,66,1};
    vt[19] = '{0,0,0,0,0,0,     0,0,0,0,0,66,1};

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_request", request, 0);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_memwrite", memwrite, 0);
    reset = 1'b1;
    use_model = 1'b1;
    step();
    chk("ready_after_release", cpu_ready, 1);

    use_model = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].rq, vt[i].we, vt[i].a, vt[i].wd, vt[i].g, vt[i].md);
      step();
      chk($sformatf("v%0d_request", i), request, vt[i].e_req);
      chk($sformatf("v%0d_adr", i), adr, vt[i].e_adr);
      chk($sformatf("v%0d_memwrite", i), memwrite, vt[i].e_mw);
      chk($sformatf("v%0d_writedata", i), writedata, vt[i].e_wd);
      chk($sformatf("v%0d_done", i), cpu_done, vt[i].e_done);
      chk($sformatf("v%0d_err", i), cpu_err, 0);
      chk($sformatf("v%0d_rdata", i), cpu_rdata, vt[i].e_rdata);
      chk($sformatf("v%0d_ready", i), cpu_ready, vt[i].e_ready);
    end
    use_model = 1'b1;

`ifdef BUS_REQUESTER_TIMEOUT_EN
    saved_rdata = cpu_rdata;
    drive(1, 0, 7, 0, 0, 0); step();
    chk("to_req", request, 1);
    drive(1, 0, 8, 0, 0, 0); step();
    chk("to_pend_ready", cpu_ready, 0);
    drive(0, 0, 0, 0, 0, 0); step(); step();
    chk("to_wait_done", cpu_done, 0);
    chk("to_wait_req", request, 1);
    step();
    chk("to_abort_done", cpu_done, 1);
    chk("to_abort_err", cpu_err, 1);
    chk("to_abort_req", request, 0);
    chk("to_abort_rdata", cpu_rdata, saved_rdata);
    step();
    chk("to_reissue_req", request, 1);
    chk("to_reissue_adr", adr, 8);
    chk("to_reissue_done", cpu_done, 0);
    drive(0, 0, 0, 0, 1, 77); step();
    chk("to_p_done", cpu_done, 1);
    chk("to_p_err", cpu_err, 0);
    chk("to_p_rdata", cpu_rdata, 77);
    drive(0, 0, 0, 0, 0, 0); step();
`endif

    drive(1, 1, 8'h21, 8'h5A, 0, 0); step();
    chk("rs_memwrite", memwrite, 1);
    drive(1, 0, 8'h22, 0, 0, 0); step();
    chk("rs_pending", cpu_ready, 0);
    drive(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("rs_req_now", request, 0);
    chk("rs_mw_now", memwrite, 0);
    chk("rs_done_now", cpu_done, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    step();
    chk("rs_no_stale", request, 0);
    drive(1, 0, 8'h30, 0, 0, 0); step();
    chk("rs_new_adr", adr, 8'h30);
    drive(0, 0, 0, 0, 1, 8'h44); step();
    chk("rs_new_done", cpu_done, 1);
    chk("rs_new_rdata", cpu_rdata, 8'h44);
    drive(0, 0, 0, 0, 0, 0); step();
    chk("rs_idle_after", request, 0);

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), W'($urandom), W'($urandom),
            ($urandom_range(0, 9) < 4), W'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
